// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the execute-stage ALU.
package alu_pkg;

    localparam int ALUOP_W = 5;

    localparam logic [ALUOP_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_XOR    = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR     = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_AND    = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL    = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLT    = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLTU   = 5'd9;
    localparam logic [ALUOP_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [ALUOP_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [ALUOP_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [ALUOP_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [ALUOP_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [ALUOP_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [ALUOP_W-1:0] ALU_REM    = 5'd16;
    localparam logic [ALUOP_W-1:0] ALU_REMU   = 5'd17;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } alu_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, one step per cycle, sign correction applied on the done cycle.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ALUOP_W-1:0] op,
    input  logic [XLEN-1:0]    in1,
    input  logic [XLEN-1:0]    in2,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    localparam int CW = $clog2(XLEN) + 1;

    logic              active;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   opnd;
    logic              is_div_q;
    logic              sel_hi_q;
    logic              neg_q;

    logic              s1, s2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              st_div, st_hi, st_neg;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] full, prod;
    logic [XLEN-1:0]   half;

    always_comb begin
        s1 = ((op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
              (op == ALU_DIV) || (op == ALU_REM)) && in1[XLEN-1];
        s2 = ((op == ALU_MUL) || (op == ALU_MULH) ||
              (op == ALU_DIV) || (op == ALU_REM)) && in2[XLEN-1];
        mag1   = s1 ? -in1 : in1;
        mag2   = s2 ? -in2 : in2;
        st_div = (op >= ALU_DIV);
        st_hi  = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU) ||
                 (op == ALU_REM) || (op == ALU_REMU);
        // Remainder follows the dividend; everything else follows the operand sign product.
        st_neg = ((op == ALU_REM) || (op == ALU_REMU)) ? s1 : (s1 ^ s2);
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active   <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            cnt      <= CW'(XLEN);
            acc_hi   <= '0;
            acc_lo   <= st_div ? mag1 : mag2;
            opnd     <= st_div ? mag2 : mag1;
            is_div_q <= st_div;
            sel_hi_q <= st_hi;
            neg_q    <= st_neg;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
                if (is_div_q) begin
                    if (!div_diff[XLEN]) begin
                        acc_hi <= div_diff[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
            end
        end
    end

    // Quotient ends in acc_lo, remainder in acc_hi; product spans both.
    always_comb begin
        full = {acc_hi, acc_lo};
        prod = neg_q ? -full : full;
        half = sel_hi_q ? acc_hi : acc_lo;
        if (is_div_q) begin
            result = neg_q ? -half : half;
        end else begin
            result = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
        done = active && (cnt == '0);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle integer ops, short-cut DIV/REM corner cases,
// and an iterative MUL/DIV engine behind a two-state FSM and one output register.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_in_valid,
    output logic               io_in_ready,
    input  logic [XLEN-1:0]    io_alu_in1,
    input  logic [XLEN-1:0]    io_alu_in2,
    input  logic [ALUOP_W-1:0] io_aluop,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic [XLEN-1:0]    io_alu_result,
    output logic               io_zero,
    output logic               io_busy,
    output alu_state_e         dbg_state
);

    localparam int              SHW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // Valid never depends on ready; once raised, the output holds until taken.
    // Input ready requires IDLE and a free (or draining) output register.
    alu_state_e      state_q, state_d;
    logic            accept;
    logic            go_iter;
    logic            eng_start, eng_done;
    logic [XLEN-1:0] eng_res;
    logic [XLEN-1:0] basic_res;
    logic [SHW-1:0]  shamt;
    logic            opnd_eq, zero_pend;
    logic            div_zero, div_ovf, signed_div;
    logic            is_mul_op, is_div_op, shortcut;

    assign io_in_ready = (state_q == ST_IDLE) && (!io_out_valid || io_out_ready);
    assign accept      = io_in_valid && io_in_ready;
    assign eng_start   = accept && go_iter;
    assign io_busy     = (state_q == ST_ITER);
    assign dbg_state   = state_q;
    assign shamt       = io_alu_in2[SHW-1:0];
    assign opnd_eq     = (io_alu_in1 == io_alu_in2);

    always_comb begin
        is_mul_op  = (io_aluop >= ALU_MUL) && (io_aluop <= ALU_MULHU);
        is_div_op  = (io_aluop >= ALU_DIV) && (io_aluop <= ALU_REMU);
        signed_div = (io_aluop == ALU_DIV) || (io_aluop == ALU_REM);
        div_zero   = (io_alu_in2 == '0);
        div_ovf    = signed_div && (io_alu_in1 == INT_MIN) && (io_alu_in2 == '1);
        shortcut   = is_div_op && (div_zero || div_ovf);
        go_iter    = MULDIV_EN && (is_mul_op || (is_div_op && !shortcut));
    end

    always_comb begin
        basic_res = '0;
        case (io_aluop)
            ALU_ADD:  basic_res = io_alu_in1 + io_alu_in2;
            ALU_SUB:  basic_res = io_alu_in1 - io_alu_in2;
            ALU_XOR:  basic_res = io_alu_in1 ^ io_alu_in2;
            ALU_OR:   basic_res = io_alu_in1 | io_alu_in2;
            ALU_AND:  basic_res = io_alu_in1 & io_alu_in2;
            ALU_SLL:  basic_res = io_alu_in1 << shamt;
            ALU_SRL:  basic_res = io_alu_in1 >> shamt;
            ALU_SRA:  basic_res = $signed(io_alu_in1) >>> shamt;
            ALU_SLT:  basic_res = {{(XLEN-1){1'b0}}, $signed(io_alu_in1) < $signed(io_alu_in2)};
            ALU_SLTU: basic_res = {{(XLEN-1){1'b0}}, io_alu_in1 < io_alu_in2};
            ALU_DIV, ALU_DIVU: begin
                if (MULDIV_EN && div_zero)     basic_res = '1;
                else if (MULDIV_EN && div_ovf) basic_res = INT_MIN;
            end
            ALU_REM, ALU_REMU: begin
                // Overflowing REM yields 0, which is already the default.
                if (MULDIV_EN && div_zero) basic_res = io_alu_in1;
            end
            default:  basic_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (eng_start) state_d = ST_ITER;
            ST_ITER: if (eng_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_out_valid  <= 1'b0;
            io_alu_result <= '0;
            io_zero       <= 1'b0;
            zero_pend     <= 1'b0;
        end else begin
            if (accept && !go_iter) begin
                io_out_valid  <= 1'b1;
                io_alu_result <= basic_res;
                io_zero       <= opnd_eq;
            end else if ((state_q == ST_ITER) && eng_done) begin
                io_out_valid  <= 1'b1;
                io_alu_result <= eng_res;
                io_zero       <= zero_pend;
            end else if (io_out_ready) begin
                io_out_valid <= 1'b0;
            end
            // Zero flag of an iterative op waits here so the visible flag stays tied to its result.
            if (accept) zero_pend <= opnd_eq;
        end
    end

    if (MULDIV_EN) begin : g_muldiv
        muldiv_iter #(.XLEN(XLEN)) u_muldiv (
            .clock  (clock),
            .reset  (reset),
            .start  (eng_start),
            .op     (io_aluop),
            .in1    (io_alu_in1),
            .in2    (io_alu_in2),
            .done   (eng_done),
            .result (eng_res)
        );
    end else begin : g_no_muldiv
        assign eng_done = 1'b0;
        assign eng_res  = '0;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32): basic ops, iterative MUL/DIV latency,
// DIV/REM short-cuts, output back-pressure and reset during an iteration.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic               clock;
    logic               reset;
    logic               io_in_valid;
    logic               io_in_ready;
    logic [XLEN-1:0]    io_alu_in1;
    logic [XLEN-1:0]    io_alu_in2;
    logic [ALUOP_W-1:0] io_aluop;
    logic               io_out_valid;
    logic               io_out_ready;
    logic [XLEN-1:0]    io_alu_result;
    logic               io_zero;
    logic               io_busy;
    alu_state_e         dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_alu_in1    (io_alu_in1),
        .io_alu_in2    (io_alu_in2),
        .io_aluop      (io_aluop),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_alu_result (io_alu_result),
        .io_zero       (io_zero),
        .io_busy       (io_busy),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Present one op, wait (bounded) for ready, return #1 after the accept edge.
    task automatic issue(input logic [ALUOP_W-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n;
        n = 0;
        io_in_valid = 1'b1;
        io_aluop    = op;
        io_alu_in1  = a;
        io_alu_in2  = b;
        #1;
        while (!io_in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) check("issue_ready_timeout", {31'b0, io_in_ready}, 32'd1);
        @(posedge clock); #1;
        io_in_valid = 1'b0;
    endtask

    task automatic run_iter(input string tag, input logic [ALUOP_W-1:0] op,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [XLEN-1:0] exp_res, input logic exp_zero);
        int   n;
        logic busy_ok;
        issue(op, a, b);
        n = 0;
        busy_ok = 1'b1;
        while (!io_out_valid && n < 100) begin
            if (!(io_busy === 1'b1 && io_in_ready === 1'b0)) busy_ok = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_busy_stall"}, {31'b0, busy_ok}, 32'd1);
        check({tag, "_result"}, io_alu_result, exp_res);
        check({tag, "_zero"}, {31'b0, io_zero}, {31'b0, exp_zero});
    endtask

    task automatic run_basic(input string tag, input logic [ALUOP_W-1:0] op,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] exp_res, input logic exp_zero);
        issue(op, a, b);
        check({tag, "_valid"}, {31'b0, io_out_valid}, 32'd1);
        check({tag, "_result"}, io_alu_result, exp_res);
        check({tag, "_zero"}, {31'b0, io_zero}, {31'b0, exp_zero});
    endtask

    initial begin
        logic stale;

        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        io_aluop     = '0;
        io_alu_in1   = '0;
        io_alu_in2   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", {31'b0, io_out_valid}, 32'd0);
        check("reset_result", io_alu_result, 32'd0);
        check("reset_zero", {31'b0, io_zero}, 32'd0);
        check("reset_busy", {31'b0, io_busy}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Single-cycle ops, issued back to back
        run_basic("add_wrap", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        run_basic("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b1);
        run_basic("sra", ALU_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
        run_basic("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
        run_basic("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        run_basic("sll", ALU_SLL, 32'h8000_0001, 32'h21, 32'h0000_0002, 1'b0);
        run_basic("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0);
        run_basic("undef", 5'd20, 32'd1, 32'd2, 32'd0, 1'b0);

        // Iterative engine
        run_iter("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        run_iter("mulh", ALU_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
        run_iter("mul", ALU_MUL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0);
        run_iter("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_iter("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_iter("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_iter("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        run_iter("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0);

        // Short-cut divides complete in one cycle without the engine
        run_basic("div_by0", ALU_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0);
        check("div_by0_busy", {31'b0, io_busy}, 32'd0);
        run_basic("remu_by0", ALU_REMU, 32'd7, 32'd0, 32'd7, 1'b0);
        run_basic("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_basic("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check("rem_ovf_busy", {31'b0, io_busy}, 32'd0);

        // Back-pressure with a queued op
        run_basic("bp_first", ALU_ADD, 32'd9, 32'd9, 32'd18, 1'b1);
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_aluop     = ALU_SUB;
        io_alu_in1   = 32'd7;
        io_alu_in2   = 32'd2;
        repeat (5) begin
            @(posedge clock); #1;
            check("bp_hold_valid", {31'b0, io_out_valid}, 32'd1);
            check("bp_hold_result", io_alu_result, 32'd18);
            check("bp_hold_zero", {31'b0, io_zero}, 32'd1);
            check("bp_in_ready", {31'b0, io_in_ready}, 32'd0);
        end
        io_out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, io_in_ready}, 32'd1);
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        check("bp_next_valid", {31'b0, io_out_valid}, 32'd1);
        check("bp_next_result", io_alu_result, 32'd5);
        check("bp_next_zero", {31'b0, io_zero}, 32'd0);
        @(posedge clock); #1;
        check("bp_drained", {31'b0, io_out_valid}, 32'd0);

        // Reset in the middle of an iteration
        issue(ALU_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        #1;
        check("mid_iter_busy", {31'b0, io_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, io_out_valid}, 32'd0);
        check("abort_busy", {31'b0, io_busy}, 32'd0);
        check("abort_result", io_alu_result, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (io_out_valid !== 1'b0) stale = 1'b1;
        end
        check("no_stale_result", {31'b0, stale}, 32'd0);
        run_basic("post_reset_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0);

        @(posedge clock); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
